// File: rtl/ahb_decoder_mux.sv
// ahb_decoder_mux
// AHB-Lite address decoder and slave-to-master response multiplexer.
// HADDR MSBs select one of NUM_SLAVES equal regions (one-hot HSEL).
// A registered data-phase owner (dsel) steers HRDATA/HREADY/HRESP back to the master.
// Unmapped addresses go to a built-in default slave.
// Optional feature macro: AHB_DECODER_MUX_ERR_EN
//   defined     - the default slave answers NONSEQ/SEQ with the two-cycle ERROR response
//   not defined - the default slave always answers zero-wait OKAY with zero data
module ahb_decoder_mux #(
    parameter int NUM_SLAVES = 2,
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                             HCLK,
    input  logic                             HRESET,
    input  logic [ADDR_WIDTH-1:0]            HADDR,
    input  logic [1:0]                       HTRANS,
    output logic [NUM_SLAVES-1:0]            HSEL,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] HRDATA_S,
    input  logic [NUM_SLAVES-1:0]            HREADYOUT_S,
    input  logic [NUM_SLAVES-1:0]            HRESP_S,
    output logic [DATA_WIDTH-1:0]            HRDATA,
    output logic                             HREADY,
    output logic                             HRESP
);

    localparam int SEL_WIDTH = $clog2(NUM_SLAVES);
    localparam logic [SEL_WIDTH:0] NUM_SLAVES_W = (SEL_WIDTH + 1)'(NUM_SLAVES);

    logic [SEL_WIDTH-1:0]  decode_idx_s;
    logic                  decode_map_s;
    logic [NUM_SLAVES-1:0] hsel_s;
    logic [SEL_WIDTH-1:0]  dsel_idx_r;
    logic                  dsel_map_r;
    logic [DATA_WIDTH-1:0] hrdata_s;
    logic                  hready_s;
    logic                  hresp_s;
    logic                  dflt_ready_s;
    logic                  dflt_resp_s;
    logic                  unused_inputs_s;

    // Region index from the address MSBs; indices past NUM_SLAVES are unmapped.
    assign decode_idx_s = HADDR[ADDR_WIDTH-1 -: SEL_WIDTH];
    assign decode_map_s = ({1'b0, decode_idx_s} < NUM_SLAVES_W);

    // Low address bits and HTRANS[0] carry no decode information.
    assign unused_inputs_s = ^{HADDR, HTRANS};

    // One-hot select straight from the address; all zeros for unmapped regions.
    always_comb begin
        hsel_s = '0;
        if (decode_map_s) begin
            hsel_s[decode_idx_s] = 1'b1;
        end else begin
            hsel_s = '0;
        end
    end

    // Data-phase owner: captures the decode whenever the bus advances, frozen during wait states.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            dsel_map_r <= 1'b0;
            dsel_idx_r <= '0;
        end else if (hready_s) begin
            dsel_map_r <= decode_map_s;
            dsel_idx_r <= decode_idx_s;
        end else begin
            dsel_map_r <= dsel_map_r;
            dsel_idx_r <= dsel_idx_r;
        end
    end

`ifdef AHB_DECODER_MUX_ERR_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ERR1 = 2'b01,
        ST_ERR2 = 2'b10
    } dflt_state_t;

    dflt_state_t state_r;
    dflt_state_t state_nx_s;

    // Default-slave state register; reset aborts an ERROR response immediately.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Default-slave next state: an accepted unmapped NONSEQ/SEQ starts the ERROR pair.
    always_comb begin
        state_nx_s = ST_IDLE;
        case (state_r)
            ST_IDLE, ST_ERR2: begin
                if (hready_s && !decode_map_s && HTRANS[1]) begin
                    state_nx_s = ST_ERR1;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_ERR1: state_nx_s = ST_ERR2;
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // Default-slave response: ERR1 stalls with ERROR, ERR2 completes with ERROR.
    always_comb begin
        dflt_ready_s = 1'b1;
        dflt_resp_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                dflt_ready_s = 1'b1;
                dflt_resp_s  = 1'b0;
            end
            ST_ERR1: begin
                dflt_ready_s = 1'b0;
                dflt_resp_s  = 1'b1;
            end
            ST_ERR2: begin
                dflt_ready_s = 1'b1;
                dflt_resp_s  = 1'b1;
            end
            default: begin
                dflt_ready_s = 1'b1;
                dflt_resp_s  = 1'b0;
            end
        endcase
    end
`else
    // Without the ERROR feature the default slave is a zero-wait OKAY sink.
    assign dflt_ready_s = 1'b1;
    assign dflt_resp_s  = 1'b0;
`endif

    // Response mux: the data-phase owner drives the master; the default slave returns zero data.
    always_comb begin
        hrdata_s = '0;
        hready_s = dflt_ready_s;
        hresp_s  = dflt_resp_s;
        if (dsel_map_r) begin
            hrdata_s = HRDATA_S[32'(dsel_idx_r) * DATA_WIDTH +: DATA_WIDTH];
            hready_s = HREADYOUT_S[dsel_idx_r];
            hresp_s  = HRESP_S[dsel_idx_r];
        end else begin
            hrdata_s = '0;
            hready_s = dflt_ready_s;
            hresp_s  = dflt_resp_s;
        end
    end

    assign HSEL   = hsel_s;
    assign HRDATA = hrdata_s;
    assign HREADY = hready_s;
    assign HRESP  = hresp_s;

endmodule

// File: tb/tb_ahb_decoder_mux.sv
// Self-checking bench for ahb_decoder_mux: a 2-slave and a 3-slave instance.
// Expected data-phase responses are queued when the address phase is driven
// and popped/compared one cycle later. Expectations follow AHB_DECODER_MUX_ERR_EN.
module tb_ahb_decoder_mux;

`ifdef AHB_DECODER_MUX_ERR_EN
    localparam bit E = 1'b1;
`else
    localparam bit E = 1'b0;
`endif

    localparam logic [31:0] D0 = 32'hA5A5_A5A5;
    localparam logic [31:0] D1 = 32'h1234_5678;
    localparam logic [31:0] D2 = 32'hDEAD_BEEF;

    typedef struct {
        logic [3:0]  addr;
        logic [1:0]  trans;
        logic [2:0]  rdy;
        logic [2:0]  rsp;
        logic [2:0]  hsel;
        logic        nx;
        logic [31:0] rdata;
        logic        ready;
        logic        resp;
    } row_t;

    typedef struct {
        logic [31:0] rdata;
        logic        ready;
        logic        resp;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   sel_dut = 0;

    logic hclk   = 1'b0;
    logic hreset = 1'b1;

    logic [3:0]  a2_haddr = 4'h0;
    logic [1:0]  a2_htrans = 2'b00;
    logic [1:0]  a2_rdy = 2'b11;
    logic [1:0]  a2_rsp = 2'b00;
    logic [63:0] a2_hrdata_s;
    logic [1:0]  a2_hsel;
    logic [31:0] a2_hrdata;
    logic        a2_hready, a2_hresp;

    logic [3:0]  b3_haddr = 4'h0;
    logic [1:0]  b3_htrans = 2'b00;
    logic [2:0]  b3_rdy = 3'b111;
    logic [2:0]  b3_rsp = 3'b000;
    logic [95:0] b3_hrdata_s;
    logic [2:0]  b3_hsel;
    logic [31:0] b3_hrdata;
    logic        b3_hready, b3_hresp;

    logic [2:0]  obs_hsel;
    logic [31:0] obs_hrdata;
    logic        obs_hready, obs_hresp;

    always #5 hclk = ~hclk;

    assign a2_hrdata_s = {D1, D0};
    assign b3_hrdata_s = {D2, D1, D0};

    ahb_decoder_mux #(.NUM_SLAVES(2), .ADDR_WIDTH(4), .DATA_WIDTH(32)) u_dut2 (
        .HCLK(hclk), .HRESET(hreset), .HADDR(a2_haddr), .HTRANS(a2_htrans),
        .HSEL(a2_hsel), .HRDATA_S(a2_hrdata_s), .HREADYOUT_S(a2_rdy), .HRESP_S(a2_rsp),
        .HRDATA(a2_hrdata), .HREADY(a2_hready), .HRESP(a2_hresp)
    );

    ahb_decoder_mux #(.NUM_SLAVES(3), .ADDR_WIDTH(4), .DATA_WIDTH(32)) u_dut3 (
        .HCLK(hclk), .HRESET(hreset), .HADDR(b3_haddr), .HTRANS(b3_htrans),
        .HSEL(b3_hsel), .HRDATA_S(b3_hrdata_s), .HREADYOUT_S(b3_rdy), .HRESP_S(b3_rsp),
        .HRDATA(b3_hrdata), .HREADY(b3_hready), .HRESP(b3_hresp)
    );

    always_comb begin
        if (sel_dut == 0) begin
            obs_hsel   = {1'b0, a2_hsel};
            obs_hrdata = a2_hrdata;
            obs_hready = a2_hready;
            obs_hresp  = a2_hresp;
        end else begin
            obs_hsel   = b3_hsel;
            obs_hrdata = b3_hrdata;
            obs_hready = b3_hready;
            obs_hresp  = b3_hresp;
        end
    end

    task automatic drive_cycle(input row_t r);
        @(posedge hclk);
        #1;
        if (sel_dut == 0) begin
            a2_haddr  = r.addr;
            a2_htrans = r.trans;
            a2_rdy    = r.rdy[1:0];
            a2_rsp    = r.rsp[1:0];
        end else begin
            b3_haddr  = r.addr;
            b3_htrans = r.trans;
            b3_rdy    = r.rdy;
            b3_rsp    = r.rsp;
        end
    endtask

    task automatic test_reset();
        a2_haddr = 4'hA;
        b3_haddr = 4'hC;
        @(negedge hclk);
        checks++;
        if ({a2_hrdata, a2_hready, a2_hresp} !== {32'h0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_resp2: got %h/%b/%b expected 0/1/0", a2_hrdata, a2_hready, a2_hresp);
        end
        checks++;
        if ({b3_hrdata, b3_hready, b3_hresp} !== {32'h0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_resp3: got %h/%b/%b expected 0/1/0", b3_hrdata, b3_hready, b3_hresp);
        end
        checks++;
        if (a2_hsel !== 2'b10) begin
            errors++;
            $display("FAIL reset_hsel2: got %b expected 10", a2_hsel);
        end
        checks++;
        if (b3_hsel !== 3'b000) begin
            errors++;
            $display("FAIL reset_hsel3: got %b expected 000", b3_hsel);
        end
        a2_haddr = 4'h2;
        b3_haddr = 4'h9;
        #1;
        checks++;
        if (a2_hsel !== 2'b01) begin
            errors++;
            $display("FAIL reset_hsel2_follow: got %b expected 01", a2_hsel);
        end
        checks++;
        if (b3_hsel !== 3'b100) begin
            errors++;
            $display("FAIL reset_hsel3_follow: got %b expected 100", b3_hsel);
        end
        @(negedge hclk);
        hreset   = 1'b0;
        a2_haddr = 4'h0;
        b3_haddr = 4'h0;
    endtask

    task automatic test_decode_mux();
        row_t t[4];
        exp_t e;
        sel_dut = 0;
        t = '{'{4'h2, 2'b10, 3'b011, 3'b000, 3'b001, 1'b1, D0, 1'b1, 1'b0},
              '{4'hA, 2'b10, 3'b011, 3'b000, 3'b010, 1'b1, D1, 1'b1, 1'b0},
              '{4'h6, 2'b11, 3'b011, 3'b001, 3'b001, 1'b1, D0, 1'b1, 1'b0},
              '{4'h0, 2'b00, 3'b011, 3'b010, 3'b001, 1'b0, 32'h0, 1'b1, 1'b0}};
        exp_q.push_back(exp_t'{D0, 1'b1, 1'b0});
        for (int i = 0; i < 4; i++) begin
            drive_cycle(t[i]);
            @(negedge hclk);
            checks++;
            if (obs_hsel !== t[i].hsel) begin
                errors++;
                $display("FAIL decode_mux hsel row %0d: got %b expected %b", i, obs_hsel, t[i].hsel);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if ({obs_hrdata, obs_hready, obs_hresp} !== {e.rdata, e.ready, e.resp}) begin
                    errors++;
                    $display("FAIL decode_mux resp row %0d: got %h/%b/%b expected %h/%b/%b",
                             i, obs_hrdata, obs_hready, obs_hresp, e.rdata, e.ready, e.resp);
                end
            end
            if (t[i].nx) exp_q.push_back(exp_t'{t[i].rdata, t[i].ready, t[i].resp});
        end
    endtask

    task automatic test_wait_states();
        row_t t[6];
        exp_t e;
        sel_dut = 0;
        t = '{'{4'hA, 2'b10, 3'b011, 3'b000, 3'b010, 1'b1, D1, 1'b0, 1'b0},
              '{4'h1, 2'b10, 3'b001, 3'b000, 3'b001, 1'b1, D1, 1'b0, 1'b0},
              '{4'h1, 2'b10, 3'b001, 3'b000, 3'b001, 1'b1, D1, 1'b0, 1'b0},
              '{4'h1, 2'b10, 3'b001, 3'b000, 3'b001, 1'b1, D1, 1'b1, 1'b0},
              '{4'h1, 2'b10, 3'b011, 3'b000, 3'b001, 1'b1, D0, 1'b1, 1'b0},
              '{4'h0, 2'b00, 3'b011, 3'b000, 3'b001, 1'b0, 32'h0, 1'b1, 1'b0}};
        exp_q.push_back(exp_t'{D0, 1'b1, 1'b0});
        for (int i = 0; i < 6; i++) begin
            drive_cycle(t[i]);
            @(negedge hclk);
            checks++;
            if (obs_hsel !== t[i].hsel) begin
                errors++;
                $display("FAIL wait_states hsel row %0d: got %b expected %b", i, obs_hsel, t[i].hsel);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if ({obs_hrdata, obs_hready, obs_hresp} !== {e.rdata, e.ready, e.resp}) begin
                    errors++;
                    $display("FAIL wait_states resp row %0d: got %h/%b/%b expected %h/%b/%b",
                             i, obs_hrdata, obs_hready, obs_hresp, e.rdata, e.ready, e.resp);
                end
            end
            if (t[i].nx) exp_q.push_back(exp_t'{t[i].rdata, t[i].ready, t[i].resp});
        end
    endtask

    task automatic test_unmapped();
        row_t t[5];
        exp_t e;
        sel_dut = 1;
        t = '{'{4'hC, 2'b10, 3'b111, 3'b000, 3'b000, 1'b1, 32'h0, !E, E},
              '{4'hC, 2'b00, 3'b111, 3'b000, 3'b000, 1'b1, 32'h0, 1'b1, E},
              '{4'hC, 2'b00, 3'b111, 3'b000, 3'b000, 1'b1, 32'h0, 1'b1, 1'b0},
              '{4'h5, 2'b10, 3'b111, 3'b000, 3'b010, 1'b1, D1, 1'b1, 1'b0},
              '{4'h0, 2'b00, 3'b111, 3'b000, 3'b001, 1'b0, 32'h0, 1'b1, 1'b0}};
        exp_q.push_back(exp_t'{D0, 1'b1, 1'b0});
        for (int i = 0; i < 5; i++) begin
            drive_cycle(t[i]);
            @(negedge hclk);
            checks++;
            if (obs_hsel !== t[i].hsel) begin
                errors++;
                $display("FAIL unmapped hsel row %0d: got %b expected %b", i, obs_hsel, t[i].hsel);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if ({obs_hrdata, obs_hready, obs_hresp} !== {e.rdata, e.ready, e.resp}) begin
                    errors++;
                    $display("FAIL unmapped resp row %0d: got %h/%b/%b expected %h/%b/%b",
                             i, obs_hrdata, obs_hready, obs_hresp, e.rdata, e.ready, e.resp);
                end
            end
            if (t[i].nx) exp_q.push_back(exp_t'{t[i].rdata, t[i].ready, t[i].resp});
        end
    endtask

    task automatic test_back_to_back();
        row_t t[6];
        exp_t e;
        sel_dut = 1;
        t = '{'{4'hC, 2'b10, 3'b111, 3'b000, 3'b000, 1'b1, 32'h0, !E, E},
              '{4'hD, 2'b10, 3'b111, 3'b000, 3'b000, 1'b1, 32'h0, 1'b1, E},
              '{4'hD, 2'b10, 3'b111, 3'b000, 3'b000, 1'b1, 32'h0, !E, E},
              '{4'h8, 2'b10, 3'b111, 3'b000, 3'b100, 1'b1, (E ? 32'h0 : D2), 1'b1, E},
              '{4'h8, 2'b10, 3'b111, 3'b000, 3'b100, 1'b1, D2, 1'b1, 1'b0},
              '{4'h0, 2'b00, 3'b111, 3'b000, 3'b001, 1'b0, 32'h0, 1'b1, 1'b0}};
        exp_q.push_back(exp_t'{D0, 1'b1, 1'b0});
        for (int i = 0; i < 6; i++) begin
            drive_cycle(t[i]);
            @(negedge hclk);
            checks++;
            if (obs_hsel !== t[i].hsel) begin
                errors++;
                $display("FAIL back_to_back hsel row %0d: got %b expected %b", i, obs_hsel, t[i].hsel);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if ({obs_hrdata, obs_hready, obs_hresp} !== {e.rdata, e.ready, e.resp}) begin
                    errors++;
                    $display("FAIL back_to_back resp row %0d: got %h/%b/%b expected %h/%b/%b",
                             i, obs_hrdata, obs_hready, obs_hresp, e.rdata, e.ready, e.resp);
                end
            end
            if (t[i].nx) exp_q.push_back(exp_t'{t[i].rdata, t[i].ready, t[i].resp});
        end
    endtask

    task automatic test_reset_mid_err();
        row_t r;
        row_t t[2];
        exp_t e;
        sel_dut = 1;
        r = '{4'hF, 2'b10, 3'b111, 3'b000, 3'b000, 1'b0, 32'h0, 1'b1, 1'b0};
        drive_cycle(r);
        @(negedge hclk);
        checks++;
        if ({obs_hsel, obs_hrdata, obs_hready, obs_hresp} !== {3'b000, D0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid_err addr: got %b/%h/%b/%b expected 000/%h/1/0",
                     obs_hsel, obs_hrdata, obs_hready, obs_hresp, D0);
        end
        r.trans = 2'b00;
        drive_cycle(r);
        @(negedge hclk);
        checks++;
        if ({obs_hrdata, obs_hready, obs_hresp} !== {32'h0, !E, E}) begin
            errors++;
            $display("FAIL reset_mid_err err1: got %h/%b/%b expected 0/%b/%b",
                     obs_hrdata, obs_hready, obs_hresp, !E, E);
        end
        #2;
        hreset = 1'b1;
        #1;
        checks++;
        if ({obs_hrdata, obs_hready, obs_hresp} !== {32'h0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid_err async: got %h/%b/%b expected 0/1/0",
                     obs_hrdata, obs_hready, obs_hresp);
        end
        @(negedge hclk);
        hreset = 1'b0;
        t = '{'{4'h1, 2'b10, 3'b111, 3'b000, 3'b001, 1'b1, D0, 1'b1, 1'b0},
              '{4'h0, 2'b00, 3'b111, 3'b000, 3'b001, 1'b0, 32'h0, 1'b1, 1'b0}};
        exp_q.push_back(exp_t'{32'h0, 1'b1, 1'b0});
        for (int i = 0; i < 2; i++) begin
            drive_cycle(t[i]);
            @(negedge hclk);
            checks++;
            if (obs_hsel !== t[i].hsel) begin
                errors++;
                $display("FAIL after_reset hsel row %0d: got %b expected %b", i, obs_hsel, t[i].hsel);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if ({obs_hrdata, obs_hready, obs_hresp} !== {e.rdata, e.ready, e.resp}) begin
                    errors++;
                    $display("FAIL after_reset resp row %0d: got %h/%b/%b expected %h/%b/%b",
                             i, obs_hrdata, obs_hready, obs_hresp, e.rdata, e.ready, e.resp);
                end
            end
            if (t[i].nx) exp_q.push_back(exp_t'{t[i].rdata, t[i].ready, t[i].resp});
        end
    endtask

    initial begin
        test_reset();
        test_decode_mux();
        test_wait_states();
        test_unmapped();
        test_back_to_back();
        test_reset_mid_err();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
